moore_seq_detect_param: RTL and testbench

Parametrised, runtime-programmable Moore serial sequence detector; next generation of the fixed 1010 Moore detector. Matches a PAT_W-bit pattern on a 1-bit stream, with per-bit valid qualification and selectable overlapping or non-overlapping detection. Also keeps a saturating match counter. Sits behind serial receive front-ends as a frame/sync-word spotter.

---
 rtl/moore_seq_detect_param.sv | 65 ++++++
 tb/tb_moore_seq_detect_param.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/moore_seq_detect_param.sv
// moore_seq_detect_param: runtime-programmable Moore serial pattern detector with a saturating match counter.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   in_valid    qualifies in_bit for sampling
//   in_bit      serial data bit
//   overlap_en  1 = overlapping detection, 0 = non-overlapping
//   pat_load    load pat_in as the new pattern; clears history, fill and counter
//   pat_in      new pattern, MSB is the first bit received
//   out         registered one-cycle match pulse
//   match_count saturating count of matches
//   count_sat   high while match_count is all-ones
module moore_seq_detect_param #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1010,
    parameter int               CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             overlap_en,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);
    localparam int             FW   = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_W);
    logic [PAT_W-1:0] pat, hist, nh;
    logic [FW-1:0]    fill, nf;
    logic             match;
    // fill gates the compare so that reset-time zeros in hist never count as received bits
    always_comb begin
        nh    = {hist[PAT_W-2:0], in_bit};
        nf    = (fill == FULL) ? FULL : fill + 1'b1;
        match = (nf == FULL) && (nh == pat);
    end
    assign count_sat = &match_count;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat         <= DEFAULT_PAT;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else if (pat_load) begin
            pat         <= pat_in;
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
        end else if (in_valid) begin
            hist <= nh;
            out  <= match;
            // non-overlapping mode restarts the fill so the next match needs a full fresh pattern
            fill <= (match && !overlap_en) ? '0 : nf;
            if (match && !count_sat)
                match_count <= match_count + 1'b1;
        end else begin
            out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_moore_seq_detect_param.sv
// tb_moore_seq_detect_param: scoreboard bench driving a CNT_W=8 and a CNT_W=2 detector with identical stimulus.
module tb_moore_seq_detect_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0, in_bit = 1'b0, overlap_en = 1'b1, pat_load = 1'b0;
    logic [3:0] pat_in = '0;
    logic       out8, sat8, out2, sat2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    moore_seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .out(out8), .match_count(cnt8), .count_sat(sat8)
    );
    moore_seq_detect_param #(.PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .overlap_en(overlap_en), .pat_load(pat_load), .pat_in(pat_in),
        .out(out2), .match_count(cnt2), .count_sat(sat2)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit o;
        int c8;
        int c2;
    } exp_t;
    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // reference model: the valid bits received since the last clear, newest at the back
    bit   mq[$];
    bit [3:0] mpat = 4'b1010;
    int   m8 = 0, m2 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mpat = 4'b1010;
        mq.delete();
        m8 = 0;
        m2 = 0;
    endtask

    task automatic step(input bit v, input bit b, input bit ov, input bit ld, input bit [3:0] p);
        exp_t e;
        bit   hit;
        in_valid = v; in_bit = b; overlap_en = ov; pat_load = ld; pat_in = p;
        hit = 1'b0;
        if (ld) begin
            mpat = p;
            mq.delete();
            m8 = 0;
            m2 = 0;
        end else if (v) begin
            mq.push_back(b);
            if (mq.size() > 4) void'(mq.pop_front());
            hit = (mq.size() == 4) && ({mq[0], mq[1], mq[2], mq[3]} == mpat);
            if (hit) begin
                if (!ov) mq.delete();
                if (m8 < 255) m8++;
                if (m2 < 3) m2++;
            end
        end
        e.o = hit; e.c8 = m8; e.c2 = m2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out8", 32'(out8), 32'(e.o));
        check("cnt8", 32'(cnt8), 32'(e.c8));
        check("sat8", 32'(sat8), 32'(e.c8 == 255));
        check("out2", 32'(out2), 32'(e.o));
        check("cnt2", 32'(cnt2), 32'(e.c2));
        check("sat2", 32'(sat2), 32'(e.c2 == 3));
        in_valid = 1'b0; pat_load = 1'b0;
    endtask

    task automatic feed(input bit [15:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, 4'b0);
    endtask

    task automatic load(input bit [3:0] p);
        step(1'b0, 1'b0, 1'b1, 1'b1, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("rst_out", 32'(out8), 0);
        check("rst_cnt", 32'(cnt8), 0);
        check("rst_sat", 32'(sat2), 0);
        @(negedge clk);
        reset = 1'b1;
        // overlapping stream: pulses after 6th and 8th bits
        feed(16'b1_1101_0101, 9, 1'b1);
        check("t1_cnt", 32'(cnt8), 2);
        // non-overlapping: the 6th-bit match is suppressed
        load(4'b1010);
        feed(16'b1010_1010, 8, 1'b0);
        check("t2_cnt", 32'(cnt8), 2);
        // gaps do not break a partial match
        load(4'b1010);
        feed(16'b10, 2, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0);
        feed(16'b10, 2, 1'b1);
        check("t3_cnt", 32'(cnt8), 1);
        // narrow counter saturates at 3 while out keeps pulsing
        load(4'b1010);
        feed(16'b10_1010_1010, 10, 1'b1);
        check("t5_cnt2", 32'(cnt2), 3);
        check("t5_sat2", 32'(sat2), 1);
        check("t5_cnt8", 32'(cnt8), 4);
        // pattern load clears counter and fill mid-pattern
        feed(16'b110, 3, 1'b1);
        load(4'b1101);
        check("t4_clr", 32'(cnt8), 0);
        check("t4_sat", 32'(sat2), 0);
        feed(16'b1101, 4, 1'b1);
        check("t4_cnt", 32'(cnt8), 1);
        // asynchronous reset mid-cycle restores the default pattern
        feed(16'b101, 3, 1'b1);
        feed(16'b1101_1101, 8, 1'b1);
        #3;
        reset = 1'b0;
        #1;
        check("t6_out", 32'(out8), 0);
        check("t6_cnt8", 32'(cnt8), 0);
        check("t6_sat2", 32'(sat2), 0);
        check("t6_cnt2", 32'(cnt2), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        feed(16'b0, 1, 1'b1);
        feed(16'b1010, 4, 1'b1);
        check("t6_cnt", 32'(cnt8), 1);
        // all-zeros pattern still needs four received bits
        load(4'b0000);
        feed(16'b00, 2, 1'b1);
        check("t7_early", 32'(cnt8), 0);
        feed(16'b00, 2, 1'b1);
        check("t7_cnt", 32'(cnt8), 1);
        check("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
